// File: rtl/gen_scheduler.sv
// gen_scheduler: row-scan sequencer for a cellular-automaton cell array.
// Each generation reads then writes every row, followed by one CHECK cycle
// that counts the generation and decides win / lose / reload / continue.
// Optional feature macro: GEN_SCHED_STEP_EN (step pulses start one generation);
// when undefined, only run starts generations and step is ignored.
module gen_scheduler #(
    parameter int unsigned ROWS     = 16,
    parameter logic [8:0]  WIN_GENS = 9'd400
) (
    input  logic                      clka,
    input  logic                      restart,
    input  logic                      run,
    input  logic                      step,
    input  logic                      load_req,
    input  logic                      load_done,
    input  logic                      lose_sig,
    output logic                      load_grant,
    output logic                      read_en,
    output logic                      write_en,
    output logic [$clog2(ROWS)-1:0]   row_addr,
    output logic [8:0]                gen_count,
    output logic                      busy,
    output logic                      win,
    output logic                      lose,
    output logic [2:0]                state
);

    localparam int unsigned RW       = $clog2(ROWS);
    localparam int unsigned GW       = 9;
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
    localparam logic [GW-1:0] GEN_MAX  = GW'(511);

    typedef enum logic [2:0] {
        S_IDLE     = 3'b000,
        S_WIN1     = 3'b001,
        S_LOAD     = 3'b010,
        S_IREAD    = 3'b011,
        S_WRITEOUT = 3'b100,
        S_CHECK    = 3'b101,
        S_LOSE1    = 3'b110
    } state_e;

    state_e         state_q, state_d;
    logic [RW-1:0]  row_q, row_d;
    logic [GW-1:0]  gen_q, gen_d;
    logic           load_grant_q, load_grant_d;
    logic           read_en_q, read_en_d;
    logic           write_en_q, write_en_d;
    logic           busy_q, busy_d;
    logic           win_q, win_d;
    logic           lose_q, lose_d;
    logic           start_c;

    // Condition that launches a generation from IDLE
`ifdef GEN_SCHED_STEP_EN
    assign start_c = run | step;
`else
    logic step_unused;
    assign step_unused = step;
    assign start_c     = run;
`endif

    // Next state, row and generation count
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        gen_d   = gen_q;
        case (state_q)
            S_IDLE: begin
                row_d = '0;
                if (load_req) begin
                    state_d = S_LOAD;
                    gen_d   = '0;
                end else if (start_c) begin
                    state_d = S_IREAD;
                end
            end
            S_LOAD: begin
                row_d = '0;
                if (load_done) begin
                    state_d = S_IDLE;
                end
            end
            S_IREAD: begin
                state_d = S_WRITEOUT;
            end
            S_WRITEOUT: begin
                if (row_q == LAST_ROW) begin
                    // Count the generation as the scan ends so CHECK shows it
                    state_d = S_CHECK;
                    row_d   = '0;
                    gen_d   = (gen_q == GEN_MAX) ? gen_q : gen_q + GW'(1);
                end else begin
                    state_d = S_IREAD;
                    row_d   = row_q + RW'(1);
                end
            end
            S_CHECK: begin
                row_d = '0;
                if (lose_sig) begin
                    state_d = S_LOSE1;
                end else if (gen_q == WIN_GENS) begin
                    state_d = S_WIN1;
                end else if (load_req) begin
                    state_d = S_LOAD;
                    gen_d   = '0;
                end else if (run) begin
                    state_d = S_IREAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WIN1, S_LOSE1: begin
                row_d = '0;
                if (load_req) begin
                    state_d = S_LOAD;
                    gen_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                row_d   = '0;
            end
        endcase
    end

    // Output decode of the upcoming state, registered alongside it
    always_comb begin
        load_grant_d = (state_d == S_LOAD);
        read_en_d    = (state_d == S_IREAD);
        write_en_d   = (state_d == S_WRITEOUT);
        win_d        = (state_d == S_WIN1);
        lose_d       = (state_d == S_LOSE1);
        busy_d       = !((state_d == S_IDLE) || (state_d == S_WIN1) ||
                         (state_d == S_LOSE1));
    end

    // State, counters and registered outputs with synchronous restart
    always_ff @(posedge clka) begin
        if (restart) begin
            state_q      <= S_IDLE;
            row_q        <= '0;
            gen_q        <= '0;
            load_grant_q <= 1'b0;
            read_en_q    <= 1'b0;
            write_en_q   <= 1'b0;
            busy_q       <= 1'b0;
            win_q        <= 1'b0;
            lose_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            gen_q        <= gen_d;
            load_grant_q <= load_grant_d;
            read_en_q    <= read_en_d;
            write_en_q   <= write_en_d;
            busy_q       <= busy_d;
            win_q        <= win_d;
            lose_q       <= lose_d;
        end
    end

    assign state      = state_q;
    assign row_addr   = row_q;
    assign gen_count  = gen_q;
    assign load_grant = load_grant_q;
    assign read_en    = read_en_q;
    assign write_en   = write_en_q;
    assign busy       = busy_q;
    assign win        = win_q;
    assign lose       = lose_q;

endmodule

// File: tb/tb_gen_scheduler.sv
// Scoreboard bench for gen_scheduler: the driver pushes the expected
// per-cycle snapshot, a negedge monitor pops and compares it.
module tb_gen_scheduler;

    localparam int unsigned ROWS = 16;
    // Win threshold of 6 lets a generation-5 extinction be reached first.
    localparam logic [8:0]  WIN  = 9'd6;

    localparam logic [2:0] S_IDLE  = 3'b000;
    localparam logic [2:0] S_WIN1  = 3'b001;
    localparam logic [2:0] S_LOAD  = 3'b010;
    localparam logic [2:0] S_IREAD = 3'b011;
    localparam logic [2:0] S_WR    = 3'b100;
    localparam logic [2:0] S_CHECK = 3'b101;
    localparam logic [2:0] S_LOSE1 = 3'b110;

    logic       clka = 1'b0;
    logic       restart, run, step, load_req, load_done, lose_sig;
    logic       load_grant, read_en, write_en, busy, win, lose;
    logic [3:0] row_addr;
    logic [8:0] gen_count;
    logic [2:0] state;

    always #5 clka = ~clka;

    gen_scheduler #(.ROWS(ROWS), .WIN_GENS(WIN)) dut (
        .clka       (clka),
        .restart    (restart),
        .run        (run),
        .step       (step),
        .load_req   (load_req),
        .load_done  (load_done),
        .lose_sig   (lose_sig),
        .load_grant (load_grant),
        .read_en    (read_en),
        .write_en   (write_en),
        .row_addr   (row_addr),
        .gen_count  (gen_count),
        .busy       (busy),
        .win        (win),
        .lose       (lose),
        .state      (state)
    );

    typedef struct packed {
        logic [2:0] st;
        logic [3:0] row;
        logic [8:0] gen;
        logic       grant;
        logic       rd;
        logic       wr;
        logic       bsy;
        logic       w;
        logic       l;
    } snap_t;

    snap_t exp_q[$];
    int    errors = 0;
    int    checks = 0;
    bit    done   = 1'b0;

    function automatic snap_t mk(input logic [2:0] st, input int row, input int gen);
        snap_t s;
        s.st    = st;
        s.row   = 4'(row);
        s.gen   = 9'(gen);
        s.grant = (st == S_LOAD);
        s.rd    = (st == S_IREAD);
        s.wr    = (st == S_WR);
        s.bsy   = !((st == S_IDLE) || (st == S_WIN1) || (st == S_LOSE1));
        s.w     = (st == S_WIN1);
        s.l     = (st == S_LOSE1);
        return s;
    endfunction

    // One clock edge; queue what the DUT must show after it
    task automatic tick(input logic [2:0] st, input int row, input int gen);
        @(posedge clka);
        #1;
        exp_q.push_back(mk(st, row, gen));
    endtask

    // One full generation starting from the edge that enters IREAD row 0.
    // ev_kind 1 raises load_req at ev_row, 2 pulses step at ev_row.
    task automatic run_gen(input int g, input int ev_row, input int ev_kind);
        for (int r = 0; r < int'(ROWS); r++) begin
            tick(S_IREAD, r, g);
            step = 1'b0;
            if (r == ev_row && ev_kind == 1) load_req = 1'b1;
            if (r == ev_row && ev_kind == 2) step = 1'b1;
            tick(S_WR, r, g);
            step = 1'b0;
        end
        tick(S_CHECK, 0, g + 1);
    endtask

    // Monitor: every cycle check enable exclusivity and the queued snapshot
    always @(negedge clka) begin : mon
        snap_t act;
        snap_t e;
        act = {state, row_addr, gen_count, load_grant, read_en, write_en, busy, win, lose};
        checks++;
        if (read_en === 1'b1 && write_en === 1'b1) begin
            errors++;
            $display("FAIL rd_wr_overlap t=%0t: read_en=%b write_en=%b, required not both high",
                     $time, read_en, write_en);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL snapshot t=%0t: got st=%0d row=%0d gen=%0d gr/rd/wr/busy/win/lose=%b%b%b%b%b%b, required st=%0d row=%0d gen=%0d gr/rd/wr/busy/win/lose=%b%b%b%b%b%b",
                         $time, act.st, act.row, act.gen, act.grant, act.rd, act.wr, act.bsy, act.w, act.l,
                         e.st, e.row, e.gen, e.grant, e.rd, e.wr, e.bsy, e.w, e.l);
            end
        end
        if (done) begin
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL drain: %0d expected snapshots left, required 0", exp_q.size());
            end
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required bench completion");
        $fatal(1);
    end

    initial begin
        restart = 1'b1; run = 1'b0; step = 1'b0;
        load_req = 1'b0; load_done = 1'b0; lose_sig = 1'b0;
        tick(S_IDLE, 0, 0);
        tick(S_IDLE, 0, 0);
        restart = 1'b0;
        tick(S_IDLE, 0, 0);

        // Free-running: two 33-cycle generations, then idle
        run = 1'b1;
        run_gen(0, -1, 0);
        run_gen(1, -1, 0);
        run = 1'b0;
        tick(S_IDLE, 0, 2);
        tick(S_IDLE, 0, 2);

        // load_req beats run in IDLE; early drop of load_req keeps LOAD
        run = 1'b1; load_req = 1'b1;
        tick(S_LOAD, 0, 0);
        load_req = 1'b0; run = 1'b0;
        tick(S_LOAD, 0, 0);
        tick(S_LOAD, 0, 0);
        load_done = 1'b1;
        tick(S_IDLE, 0, 0);
        load_done = 1'b0;

        // restart while in LOAD
        load_req = 1'b1;
        tick(S_LOAD, 0, 0);
        restart = 1'b1;
        tick(S_IDLE, 0, 0);
        restart = 1'b0; load_req = 1'b0;
        tick(S_IDLE, 0, 0);

        // restart in WRITEOUT row 7 of generation 2 dominates run/load_req
        run = 1'b1;
        run_gen(0, -1, 0);
        for (int r = 0; r <= 7; r++) begin
            tick(S_IREAD, r, 1);
            tick(S_WR, r, 1);
        end
        restart = 1'b1; load_req = 1'b1;
        tick(S_IDLE, 0, 0);
        restart = 1'b0; load_req = 1'b0; run = 1'b0;
        tick(S_IDLE, 0, 0);

        // Extinction flagged in the CHECK of generation 5
        run = 1'b1;
        for (int g = 0; g < 5; g++) run_gen(g, -1, 0);
        lose_sig = 1'b1;
        tick(S_LOSE1, 0, 5);
        lose_sig = 1'b0; step = 1'b1;
        tick(S_LOSE1, 0, 5);
        step = 1'b0;
        tick(S_LOSE1, 0, 5);
        run = 1'b0; load_req = 1'b1;
        tick(S_LOAD, 0, 0);
        load_req = 1'b0; load_done = 1'b1;
        tick(S_IDLE, 0, 0);
        load_done = 1'b0;

        // Win after generation 6; win outranks a same-cycle load_req
        run = 1'b1;
        for (int g = 0; g < 6; g++) run_gen(g, -1, 0);
        load_req = 1'b1;
        tick(S_WIN1, 0, 6);
        load_req = 1'b0;
        tick(S_WIN1, 0, 6);
        tick(S_WIN1, 0, 6);
        load_req = 1'b1;
        tick(S_LOAD, 0, 0);
        load_req = 1'b0; run = 1'b0; load_done = 1'b1;
        tick(S_IDLE, 0, 0);
        load_done = 1'b0;

        // load_req at row 4 waits for the scan and CHECK to finish
        run = 1'b1;
        run_gen(0, 4, 1);
        tick(S_LOAD, 0, 0);
        load_req = 1'b0; run = 1'b0; load_done = 1'b1;
        tick(S_IDLE, 0, 0);
        load_done = 1'b0;

        // Single step from IDLE; a second pulse mid-scan is dropped
        step = 1'b1;
`ifdef GEN_SCHED_STEP_EN
        run_gen(0, 2, 2);
        tick(S_IDLE, 0, 1);
        tick(S_IDLE, 0, 1);
`else
        tick(S_IDLE, 0, 0);
        step = 1'b0;
        tick(S_IDLE, 0, 0);
        tick(S_IDLE, 0, 0);
`endif

        @(posedge clka);
        #1;
        done = 1'b1;
    end

endmodule
